// File: rtl/control_fsm_if.sv
// Bus bundle between the instruction sequencer and its memories, register file and ALU.
interface control_fsm_if #(
    parameter int DATAWIDTH = 32
) ();
    logic                 imem_req_o;
    logic [DATAWIDTH-1:0] imem_addr_o;
    logic                 imem_valid_i;
    logic [31:0]          imem_data_i;

    logic [3:0]           rf_rs1_o;
    logic [3:0]           rf_rs2_o;
    logic [DATAWIDTH-1:0] rs1_data_i;
    logic [DATAWIDTH-1:0] rs2_data_i;

    logic [3:0]           alu_opcode_o;
    logic [DATAWIDTH-1:0] alu_a_o;
    logic [DATAWIDTH-1:0] alu_b_o;
    logic [DATAWIDTH-1:0] alu_result_i;

    logic                 dmem_req_o;
    logic                 dmem_we_o;
    logic [DATAWIDTH-1:0] dmem_addr_o;
    logic [DATAWIDTH-1:0] dmem_wdata_o;
    logic                 dmem_valid_i;
    logic [DATAWIDTH-1:0] dmem_rdata_i;

    logic                 rf_we_o;
    logic [3:0]           rf_rd_o;
    logic [DATAWIDTH-1:0] rf_wdata_o;

    logic                 illegal_o;

    modport master (
        output imem_req_o, imem_addr_o, rf_rs1_o, rf_rs2_o, alu_opcode_o, alu_a_o, alu_b_o,
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, rf_we_o, rf_rd_o, rf_wdata_o,
               illegal_o,
        input  imem_valid_i, imem_data_i, rs1_data_i, rs2_data_i, alu_result_i,
               dmem_valid_i, dmem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, rf_rs1_o, rf_rs2_o, alu_opcode_o, alu_a_o, alu_b_o,
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, rf_we_o, rf_rd_o, rf_wdata_o,
               illegal_o,
        output imem_valid_i, imem_data_i, rs1_data_i, rs2_data_i, alu_result_i,
               dmem_valid_i, dmem_rdata_i
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: fetch, decode, ALU issue, data memory access, write-back.
//   state  | meaning
//   FETCH  | request instruction at PC, latch into IR on imem_valid_i
//   DECODE | check opcode, present register read addresses
//   EXEC   | issue ALU op, latch result, resolve branches/jumps
//   MEM    | data memory access at RES, held until dmem_valid_i
//   WB     | one-cycle register write of RES, advance PC
//   HALT   | illegal opcode seen; absorbing until reset
module control_fsm #(
    parameter int DATAWIDTH = 32
) (
    input logic           clk_i,
    input logic           rst_ni,
    control_fsm_if.master bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BGT  = 4'd11;
    localparam logic [3:0] OP_BGE  = 4'd12;
    localparam logic [3:0] OP_JMP  = 4'd13;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] pc_q, res_q;
    logic [31:0]          ir_q;
    logic                 illegal_q;

    logic [3:0]           op;
    logic [DATAWIDTH-1:0] simm, pc_inc;
    logic                 legal, is_mem, is_br, taken;

    assign op     = ir_q[31:28];
    assign simm   = {{(DATAWIDTH-16){ir_q[15]}}, ir_q[15:0]};
    assign pc_inc = pc_q + DATAWIDTH'(4);
    assign legal  = (op <= OP_JMP);
    assign is_mem = (op == OP_LW) || (op == OP_SW);
    assign is_br  = (op == OP_BEQ) || (op == OP_BGT) || (op == OP_BGE);

    // JMP counts as always-taken so EXEC has a single PC-redirect path.
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BEQ:  taken = (bus.rs1_data_i == bus.rs2_data_i);
            OP_BGT:  taken = ($signed(bus.rs1_data_i) >  $signed(bus.rs2_data_i));
            OP_BGE:  taken = ($signed(bus.rs1_data_i) >= $signed(bus.rs2_data_i));
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.imem_valid_i) state_d = S_DECODE;
            S_DECODE: state_d = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (is_mem)                      state_d = S_MEM;
                else if (is_br || op == OP_JMP)  state_d = S_FETCH;
                else                             state_d = S_WB;
            end
            S_MEM:    if (bus.dmem_valid_i) state_d = (op == OP_SW) ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q      <= '0;
            ir_q      <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH:  if (bus.imem_valid_i) ir_q <= bus.imem_data_i;
                S_DECODE: if (!legal) illegal_q <= 1'b1;
                S_EXEC: begin
                    res_q <= bus.alu_result_i;
                    if (taken)      pc_q <= bus.alu_result_i;
                    else if (is_br) pc_q <= pc_inc;
                end
                S_MEM: begin
                    if (bus.dmem_valid_i) begin
                        if (op == OP_SW) pc_q  <= pc_inc;
                        else             res_q <= bus.dmem_rdata_i;
                    end
                end
                S_WB:     pc_q <= pc_inc;
                default: ;
            endcase
        end
    end

    // Strobes are gated by reset so an in-flight request drops the instant reset asserts.
    always_comb begin
        bus.imem_req_o   = rst_ni && (state_q == S_FETCH);
        bus.dmem_req_o   = rst_ni && (state_q == S_MEM);
        bus.dmem_we_o    = rst_ni && (state_q == S_MEM) && (op == OP_SW);
        bus.rf_we_o      = rst_ni && (state_q == S_WB);
        bus.imem_addr_o  = pc_q;
        bus.rf_rs1_o     = ir_q[23:20];
        bus.rf_rs2_o     = ir_q[19:16];
        bus.alu_opcode_o = op;
        bus.dmem_addr_o  = res_q;
        bus.dmem_wdata_o = bus.rs2_data_i;
        bus.rf_rd_o      = ir_q[27:24];
        bus.rf_wdata_o   = res_q;
        bus.illegal_o    = illegal_q;
        case (op)
            OP_ADDI, OP_LW, OP_SW: begin
                bus.alu_a_o = bus.rs1_data_i;
                bus.alu_b_o = simm;
            end
            OP_BEQ, OP_BGT, OP_BGE, OP_JMP: begin
                bus.alu_a_o = pc_q;
                bus.alu_b_o = simm;
            end
            default: begin
                bus.alu_a_o = bus.rs1_data_i;
                bus.alu_b_o = bus.rs2_data_i;
            end
        endcase
    end
endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed vector table, hand-written corner sequences, random programs vs ISA model.
module tb_control_fsm;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BGT  = 4'd11;
    localparam logic [3:0] OP_BGE  = 4'd12;
    localparam logic [3:0] OP_JMP  = 4'd13;

    logic clk_i;
    logic rst_ni;

    control_fsm_if #(.DATAWIDTH(32)) bus ();
    control_fsm #(.DATAWIDTH(32)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rf [16];
    logic [31:0] m_rf [16];

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                                       input logic [3:0] rs2, input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    // Combinational environment: register-file read ports, ALU, data memory read data.
    always_comb begin
        bus.rs1_data_i   = rf[bus.rf_rs1_o];
        bus.rs2_data_i   = rf[bus.rf_rs2_o];
        bus.alu_result_i = alu_f(bus.alu_opcode_o, bus.alu_a_o, bus.alu_b_o);
        bus.dmem_rdata_i = mem_f(bus.dmem_addr_o);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Observations of the last instruction run by exec_one.
    logic [31:0] f_addr, n_addr, o_wdata, o_maddr, o_mwdata;
    logic [3:0]  o_rd;
    logic        req_held, tmo, o_mwe;
    int          exit_lat, we_cnt, we_lat, dm_cnt;

    task automatic do_reset();
        bus.imem_valid_i = 1'b0;
        bus.imem_data_i  = 32'd0;
        bus.dmem_valid_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic setup(input logic [31:0] r1v, input logic [31:0] r2v);
        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        rf[1] = r1v;
        rf[2] = r2v;
        do_reset();
    endtask

    task automatic exec_one(input logic [31:0] instr, input int iw, input int dw);
        int n;
        int dleft;
        int lat;
        tmo = 1'b0; req_held = 1'b1; we_cnt = 0; dm_cnt = 0; we_lat = 0;
        n = 0;
        while (!bus.imem_req_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!bus.imem_req_o) begin
            tmo = 1'b1;
            return;
        end
        f_addr = bus.imem_addr_o;
        for (int i = 0; i < iw; i++) begin
            if (!bus.imem_req_o) req_held = 1'b0;
            @(negedge clk_i);
        end
        if (!bus.imem_req_o) req_held = 1'b0;
        bus.imem_valid_i = 1'b1;
        bus.imem_data_i  = instr;
        @(negedge clk_i);
        bus.imem_valid_i = 1'b0;
        lat   = 2;
        dleft = dw;
        while (!bus.imem_req_o && !bus.illegal_o && lat < 60) begin
            if (bus.rf_we_o) begin
                we_cnt++;
                we_lat  = lat;
                o_rd    = bus.rf_rd_o;
                o_wdata = bus.rf_wdata_o;
                rf[bus.rf_rd_o] = bus.rf_wdata_o;
            end
            if (bus.dmem_req_o) begin
                dm_cnt++;
                o_maddr  = bus.dmem_addr_o;
                o_mwe    = bus.dmem_we_o;
                o_mwdata = bus.dmem_wdata_o;
                if (dleft == 0) bus.dmem_valid_i = 1'b1;
                else begin
                    bus.dmem_valid_i = 1'b0;
                    dleft--;
                end
            end else begin
                bus.dmem_valid_i = 1'b0;
            end
            @(negedge clk_i);
            lat++;
        end
        bus.dmem_valid_i = 1'b0;
        if (lat >= 60) tmo = 1'b1;
        exit_lat = lat;
        n_addr   = bus.imem_addr_o;
    endtask

    task automatic check_result(input string tag, input logic [31:0] e_fetch, input logic [31:0] e_npc,
                                input logic e_we, input logic [3:0] e_rd, input logic [31:0] e_wd,
                                input int e_lat, input logic e_mem, input logic [31:0] e_maddr,
                                input logic e_mwe, input logic [31:0] e_mwd, input int e_dm);
        check({tag, " timeout"}, 32'(tmo), 32'd0);
        check({tag, " fetch_addr"}, f_addr, e_fetch);
        check({tag, " fetch_req_held"}, 32'(req_held), 32'd1);
        check({tag, " next_pc"}, n_addr, e_npc);
        check({tag, " latency"}, exit_lat - 1, e_lat);
        check({tag, " rf_we_cycles"}, we_cnt, e_we ? 32'd1 : 32'd0);
        if (e_we) begin
            check({tag, " rf_rd"}, 32'(o_rd), 32'(e_rd));
            check({tag, " rf_wdata"}, o_wdata, e_wd);
            check({tag, " rf_we_cycle"}, we_lat, e_lat);
        end
        check({tag, " dmem_cycles"}, dm_cnt, e_mem ? e_dm : 0);
        if (e_mem) begin
            check({tag, " dmem_addr"}, o_maddr, e_maddr);
            check({tag, " dmem_we"}, 32'(o_mwe), 32'(e_mwe));
            if (e_mwe) check({tag, " dmem_wdata"}, o_mwdata, e_mwd);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] r1v;
        logic [31:0] r2v;
        int          dw;
        logic [31:0] npc;
        logic        we;
        logic [3:0]  rd;
        logic [31:0] wdata;
        int          lat;
        logic        mem;
        logic [31:0] maddr;
        logic        mwe;
        logic [31:0] mwd;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [3:0]  op, rd, rs1, rs2;
        logic [15:0] imm;
        logic [31:0] a, b, simm, m_pc, e_npc, e_wd, e_maddr, e_mwd;
        logic        e_we, e_mem, e_mwe;
        int          e_lat, iw, dw, m;

        vecs[0]  = '{mk(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'd5), 32'd0, 32'd0, 0, 32'd4, 1'b1, 4'd1, 32'd5, 4, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[1]  = '{mk(OP_ADD, 4'd3, 4'd1, 4'd2, 16'd0), 32'd10, 32'hFFFF_FFFF, 0, 32'd4, 1'b1, 4'd3, 32'd9, 4, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[2]  = '{mk(OP_SUB, 4'd4, 4'd1, 4'd2, 16'd0), 32'd3, 32'd5, 0, 32'd4, 1'b1, 4'd4, 32'hFFFF_FFFE, 4, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[3]  = '{mk(OP_MUL, 4'd5, 4'd1, 4'd2, 16'd0), 32'd6, 32'd7, 0, 32'd4, 1'b1, 4'd5, 32'd42, 4, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[4]  = '{mk(OP_DIV, 4'd6, 4'd1, 4'd2, 16'd0), 32'd100, 32'd7, 0, 32'd4, 1'b1, 4'd6, 32'd14, 4, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[5]  = '{mk(OP_AND, 4'd7, 4'd1, 4'd2, 16'd0), 32'hF0F0, 32'hFF00, 0, 32'd4, 1'b1, 4'd7, 32'hF000, 4, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[6]  = '{mk(OP_OR, 4'd0, 4'd1, 4'd2, 16'd0), 32'h0F, 32'hF0, 0, 32'd4, 1'b1, 4'd0, 32'hFF, 4, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[7]  = '{mk(OP_XOR, 4'd8, 4'd1, 4'd2, 16'd0), 32'hFF, 32'h0F, 0, 32'd4, 1'b1, 4'd8, 32'hF0, 4, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[8]  = '{mk(OP_BEQ, 4'd0, 4'd1, 4'd2, 16'hFFF8), 32'd7, 32'd7, 0, 32'hFFFF_FFF8, 1'b0, 4'd0, 32'd0, 3, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[9]  = '{mk(OP_BEQ, 4'd0, 4'd1, 4'd2, 16'hFFF8), 32'd7, 32'd8, 0, 32'd4, 1'b0, 4'd0, 32'd0, 3, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[10] = '{mk(OP_BGT, 4'd0, 4'd1, 4'd2, 16'h0040), 32'd1, 32'hFFFF_FFFF, 0, 32'h40, 1'b0, 4'd0, 32'd0, 3, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[11] = '{mk(OP_BGT, 4'd0, 4'd1, 4'd2, 16'h0040), 32'd5, 32'd5, 0, 32'd4, 1'b0, 4'd0, 32'd0, 3, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[12] = '{mk(OP_BGE, 4'd0, 4'd1, 4'd2, 16'h0010), 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 32'h10, 1'b0, 4'd0, 32'd0, 3, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[13] = '{mk(OP_BGE, 4'd0, 4'd1, 4'd2, 16'h0010), 32'hFFFF_FFFE, 32'd1, 0, 32'd4, 1'b0, 4'd0, 32'd0, 3, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[14] = '{mk(OP_SW, 4'd0, 4'd1, 4'd2, 16'd4), 32'h200, 32'hDEAD, 0, 32'd4, 1'b0, 4'd0, 32'd0, 4, 1'b1, 32'h204, 1'b1, 32'hDEAD};
        vecs[15] = '{mk(OP_LW, 4'd3, 4'd1, 4'd0, 16'd4), 32'h100, 32'd0, 3, 32'd4, 1'b1, 4'd3, 32'h5A5A_0104, 8, 1'b1, 32'h104, 1'b0, 32'd0};
        vecs[16] = '{mk(OP_ADDI, 4'd9, 4'd1, 4'd0, 16'hFFFF), 32'd0, 32'd0, 0, 32'd4, 1'b1, 4'd9, 32'hFFFF_FFFF, 4, 1'b0, 32'd0, 1'b0, 32'd0};

        // Reset state and first fetch after release.
        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        bus.imem_valid_i = 1'b0;
        bus.imem_data_i  = 32'd0;
        bus.dmem_valid_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("reset imem_req", 32'(bus.imem_req_o), 32'd0);
        check("reset dmem_req", 32'(bus.dmem_req_o), 32'd0);
        check("reset rf_we", 32'(bus.rf_we_o), 32'd0);
        check("reset illegal", 32'(bus.illegal_o), 32'd0);
        rst_ni = 1'b1;
        #1;
        check("release imem_req", 32'(bus.imem_req_o), 32'd1);
        check("release imem_addr", bus.imem_addr_o, 32'd0);

        for (int v = 0; v < 17; v++) begin
            setup(vecs[v].r1v, vecs[v].r2v);
            exec_one(vecs[v].instr, 0, vecs[v].dw);
            check_result($sformatf("vec%0d", v), 32'd0, vecs[v].npc, vecs[v].we, vecs[v].rd, vecs[v].wdata,
                         vecs[v].lat, vecs[v].mem, vecs[v].maddr, vecs[v].mwe, vecs[v].mwd, vecs[v].dw + 1);
        end

        // Branch from a non-zero PC, taken and not taken.
        for (int t = 0; t < 2; t++) begin
            setup(32'd7, (t == 0) ? 32'd7 : 32'd8);
            exec_one(mk(OP_JMP, 4'd0, 4'd0, 4'd0, 16'h0020), 1, 0);
            check_result("jmp20", 32'd0, 32'h20, 1'b0, 4'd0, 32'd0, 3, 1'b0, 32'd0, 1'b0, 32'd0, 0);
            exec_one(mk(OP_BEQ, 4'd0, 4'd1, 4'd2, 16'hFFF8), 2, 0);
            check_result((t == 0) ? "beq_taken" : "beq_not_taken", 32'h20, (t == 0) ? 32'h18 : 32'h24,
                         1'b0, 4'd0, 32'd0, 3, 1'b0, 32'd0, 1'b0, 32'd0, 0);
        end

        // PC wrap-around at the top of the address space.
        setup(32'd0, 32'd0);
        exec_one(mk(OP_JMP, 4'd0, 4'd0, 4'd0, 16'hFFFC), 0, 0);
        check_result("jmp_top", 32'd0, 32'hFFFF_FFFC, 1'b0, 4'd0, 32'd0, 3, 1'b0, 32'd0, 1'b0, 32'd0, 0);
        exec_one(mk(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'd1), 0, 0);
        check_result("pc_wrap", 32'hFFFF_FFFC, 32'd0, 1'b1, 4'd1, 32'd1, 4, 1'b0, 32'd0, 1'b0, 32'd0, 0);

        // Illegal opcode halts until reset.
        setup(32'd0, 32'd0);
        exec_one(32'hE123_4567, 0, 0);
        check("illegal flag", 32'(bus.illegal_o), 32'd1);
        check("illegal cycle", exit_lat, 32'd3);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            bus.imem_valid_i = 1'b1;
            if (bus.imem_req_o || bus.dmem_req_o || bus.rf_we_o || !bus.illegal_o) cnt++;
            @(negedge clk_i);
        end
        bus.imem_valid_i = 1'b0;
        check("halt absorbing", cnt, 32'd0);
        rst_ni = 1'b0;
        #1;
        check("halt reset illegal", 32'(bus.illegal_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("halt release imem_req", 32'(bus.imem_req_o), 32'd1);
        check("halt release addr", bus.imem_addr_o, 32'd0);

        // Reset during a stalled SW abandons the store.
        setup(32'h300, 32'h55);
        bus.imem_valid_i = 1'b1;
        bus.imem_data_i  = mk(OP_SW, 4'd0, 4'd1, 4'd2, 16'd0);
        @(negedge clk_i);
        bus.imem_valid_i = 1'b0;
        cnt = 0;
        while (!bus.dmem_req_o && cnt < 10) begin
            @(negedge clk_i);
            cnt++;
        end
        check("sw dmem_req", 32'(bus.dmem_req_o), 32'd1);
        check("sw dmem_we", 32'(bus.dmem_we_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("sw reset dmem_req", 32'(bus.dmem_req_o), 32'd0);
        check("sw reset dmem_we", 32'(bus.dmem_we_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("sw release imem_req", 32'(bus.imem_req_o), 32'd1);
        check("sw release addr", bus.imem_addr_o, 32'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (bus.dmem_req_o || bus.dmem_we_o) cnt++;
        end
        check("sw no write after reset", cnt, 32'd0);

        // Random programs against an ISA-level model.
        setup(32'd0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            m = int'($urandom_range(0, 6)) - 3;
            rf[i]   = m;
            m_rf[i] = m;
        end
        m_pc = 32'd0;
        for (int k = 0; k < 200; k++) begin
            op  = 4'($urandom_range(0, 13));
            rd  = 4'($urandom);
            rs1 = 4'($urandom);
            rs2 = 4'($urandom);
            if (op >= OP_BEQ) begin
                m = int'($urandom_range(0, 31)) * 4;
                if ($urandom_range(0, 1) == 1) m = -m;
                imm = 16'(m);
            end else begin
                imm = 16'($urandom);
            end
            iw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            a = m_rf[rs1];
            b = m_rf[rs2];
            simm = {{16{imm[15]}}, imm};
            e_npc = m_pc + 32'd4;
            e_we = 1'b0; e_wd = 32'd0; e_mem = 1'b0; e_maddr = 32'd0; e_mwe = 1'b0; e_mwd = 32'd0;
            e_lat = 4;
            case (op)
                OP_ADDI: begin e_we = 1'b1; e_wd = a + simm; end
                OP_LW: begin
                    e_mem = 1'b1; e_maddr = a + simm;
                    e_we = 1'b1; e_wd = mem_f(a + simm); e_lat = 5 + dw;
                end
                OP_SW: begin
                    e_mem = 1'b1; e_maddr = a + simm; e_mwe = 1'b1; e_mwd = b; e_lat = 4 + dw;
                end
                OP_BEQ: begin e_lat = 3; if (a == b) e_npc = m_pc + simm; end
                OP_BGT: begin e_lat = 3; if ($signed(a) > $signed(b)) e_npc = m_pc + simm; end
                OP_BGE: begin e_lat = 3; if ($signed(a) >= $signed(b)) e_npc = m_pc + simm; end
                OP_JMP: begin e_lat = 3; e_npc = m_pc + simm; end
                default: begin e_we = 1'b1; e_wd = alu_f(op, a, b); end
            endcase
            exec_one(mk(op, rd, rs1, rs2, imm), iw, dw);
            check_result($sformatf("rnd%0d op%0d", k, op), m_pc, e_npc, e_we, rd, e_wd, e_lat,
                         e_mem, e_maddr, e_mwe, e_mwd, dw + 1);
            if (e_we) m_rf[rd] = e_wd;
            m_pc = e_npc;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, datapath and address width.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports imem_req_o out 1, imem_addr_o out DATAWIDTH, imem_valid_i in 1, imem_data_i in 32: instruction fetch request, PC address, response strobe, instruction word.
REQ-005 SHALL have ports rf_rs1_o out 4, rf_rs2_o out 4, rs1_data_i in DATAWIDTH, rs2_data_i in DATAWIDTH: register-file read addresses and combinational read data.
REQ-006 SHALL have ports alu_opcode_o out 4, alu_a_o out DATAWIDTH, alu_b_o out DATAWIDTH, alu_result_i in DATAWIDTH: ALU operation, operands, combinational result.
REQ-007 SHALL have ports dmem_req_o out 1, dmem_we_o out 1, dmem_addr_o out DATAWIDTH, dmem_wdata_o out DATAWIDTH, dmem_valid_i in 1, dmem_rdata_i in DATAWIDTH: data memory access.
REQ-008 SHALL have ports rf_we_o out 1, rf_rd_o out 4, rf_wdata_o out DATAWIDTH: register write-back.
REQ-009 SHALL have port illegal_o  output  1  sticky illegal-opcode flag.

Function
REQ-010 SHALL decode the latched instruction IR as: IR[31:28] opcode (opcode.svh encodings), IR[27:24] rd, IR[23:20] rs1, IR[19:16] rs2, IR[15:0] imm, sign-extended to DATAWIDTH (simm).
REQ-011 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-012 FETCH: imem_req_o=1, imem_addr_o=PC, held until imem_valid_i=1; that cycle latch imem_data_i into IR, go DECODE; imem_valid_i ignored in all other states.
REQ-013 DECODE: one cycle; rf_rs1_o=IR rs1, rf_rs2_o=IR rs2 (driven from IR in all states); opcode not in opcode.svh -> set illegal_o, go HALT; else go EXEC.
REQ-014 EXEC: alu_opcode_o=IR opcode; operands: ADD/SUB/MUL/DIV/AND/OR/XOR a=rs1,b=rs2; ADDI/LW/SW a=rs1,b=simm; BEQ/BGT/BGE/JMP a=PC,b=simm; latch alu_result_i into RES.
REQ-015 EXEC next state: LW/SW -> MEM; JMP -> PC=RES, FETCH; BEQ (rs1==rs2), BGT (signed rs1>rs2), BGE (signed rs1>=rs2): taken -> PC=RES, else PC=PC+4, then FETCH; all others -> WB.
REQ-016 MEM: dmem_req_o=1, dmem_addr_o=RES, dmem_we_o=1 for SW, dmem_wdata_o=rs2_data_i, held until dmem_valid_i=1; SW then PC=PC+4, FETCH; LW latches dmem_rdata_i into RES, go WB.
REQ-017 WB: rf_we_o=1 for exactly one cycle, rf_rd_o=IR rd, rf_wdata_o=RES; PC=PC+4; go FETCH; register 0 is an ordinary writable register.
REQ-018 Outside their states, imem_req_o, dmem_req_o, dmem_we_o, rf_we_o SHALL be 0; alu_opcode_o SHALL always equal IR opcode.
REQ-019 PC arithmetic SHALL be modulo 2^DATAWIDTH (0xFFFFFFFC+4 -> 0x0); branch targets wrap identically.
REQ-020 Minimum latency (zero-wait memories): ALU op 4 cycles, branch/JMP 3, SW 4, LW 5.
REQ-021 HALT SHALL be absorbing: all request/write strobes 0, illegal_o=1, until reset.

Reset
REQ-022 rst_ni=0 SHALL immediately force state FETCH, PC=0, IR=0, RES=0, illegal_o=0, all strobes 0; outstanding requests are abandoned.
REQ-023 First fetch after reset release SHALL be address 0 on the first rising edge with rst_ni=1.

Verification
REQ-024 Reset release, imem returns ADDI r1,r0,5 (r0=0) with valid same cycle -> rf_we_o pulse, rf_rd_o=1, rf_wdata_o=5 in cycle 4, next fetch address 4.
REQ-025 BEQ r1,r2,imm=-8 at PC=0x20, r1=r2=7 -> next imem_addr_o=0x18; with r1=7,r2=8 -> 0x24.
REQ-026 LW r3,[r1+4], r1=0x100, dmem_valid_i delayed 3 cycles -> dmem_req_o held 4 cycles at addr 0x104, then rf_wdata_o=dmem_rdata_i.
REQ-027 Undefined opcode fetched -> illegal_o=1 after DECODE, no further imem_req_o until rst_ni pulsed low.
REQ-028 rst_ni asserted during MEM wait of SW -> dmem_req_o drops immediately; after release fetch at address 0, no write issued.
